hilo_mdu: RTL and testbench

- Execute-stage multiply/divide unit owning the HI/LO architectural registers.
- Consumes decoded rs/rt operands from the decode->execute pipeline register.
- Produces HI/LO for MFHI/MFLO, plus a busy flag that hazard control turns into the pipeline stall.
- Multiply and MTHI/MTLO complete in one cycle. Divide is iterative restoring, 1 bit per cycle.

---
 rtl/hilo_mdu.sv | 183 ++++++++++++++++++
 tb/tb_hilo_mdu.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mdu
// Description : Execute-stage multiply/divide unit that owns the HI/LO
//               architectural registers.
//               MULT/MULTU and MTHI/MTLO complete in one cycle.
//               DIV/DIVU use restoring division, one quotient bit per cycle,
//               followed by a sign fix-up cycle.
// Ports       : clk      - clock, rising edge
//               reset    - asynchronous, active-low
//               start    - op valid this cycle (already qualified by stage)
//               op       - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
//               rs, rt   - operands (rs is also the MTHI/MTLO source)
//               nullify  - flush: aborts divide, blocks same-cycle start
//               busy     - divide in progress (stall request)
//               done     - one-cycle pulse, HI/LO updated by previous op
//               hi, lo   - HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             nullify,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;

    localparam int                c_cnt_w    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;
    logic [WIDTH-1:0]     r_quo;     // dividend magnitude shifts out, quotient shifts in
    logic [WIDTH-1:0]     r_rem;     // partial remainder, always < divisor magnitude
    logic [WIDTH-1:0]     r_dvs;     // divisor magnitude
    logic                 r_neg_q;
    logic                 r_neg_r;

    logic                 w_accept;
    logic                 w_signed_div;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_mul_signed;
    logic [2*WIDTH-1:0]   w_mul_a;
    logic [2*WIDTH-1:0]   w_mul_b;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH:0]       w_shift;
    logic [WIDTH:0]       w_trial;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    assign w_accept     = start && (r_state == S_IDLE) && !nullify && (op <= c_op_mtlo);

    assign w_signed_div = (op == c_op_div);
    assign w_a_neg      = w_signed_div & rs[WIDTH-1];
    assign w_b_neg      = w_signed_div & rt[WIDTH-1];
    assign w_a_mag      = w_a_neg ? -rs : rs;
    assign w_b_mag      = w_b_neg ? -rt : rt;

    // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product
    // are then correct for both signed and unsigned multiplication.
    assign w_mul_signed = (op == c_op_mult);
    assign w_mul_a      = {{WIDTH{w_mul_signed & rs[WIDTH-1]}}, rs};
    assign w_mul_b      = {{WIDTH{w_mul_signed & rt[WIDTH-1]}}, rt};
    assign w_prod       = w_mul_a * w_mul_b;

    // Restoring step in WIDTH+1 bits: the top bit of the trial difference is
    // the borrow, so a magnitude of 2^(WIDTH-1) (most negative input) is safe.
    assign w_shift      = {r_rem, r_quo[WIDTH-1]};
    assign w_trial      = w_shift - {1'b0, r_dvs};

    assign w_quo_fix    = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix    = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            c_op_mult, c_op_multu: begin
                                {r_hi, r_lo} <= w_prod;
                                r_done       <= 1'b1;
                            end
                            c_op_mthi: begin
                                r_hi   <= rs;
                                r_done <= 1'b1;
                            end
                            c_op_mtlo: begin
                                r_lo   <= rs;
                                r_done <= 1'b1;
                            end
                            c_op_div, c_op_divu: begin
                                r_quo   <= w_a_mag;
                                r_rem   <= '0;
                                r_dvs   <= w_b_mag;
                                // Divide by zero yields an all-ones quotient
                                // from the magnitude loop; keep it unsigned.
                                r_neg_q <= (w_a_neg ^ w_b_neg) && (rt != '0);
                                r_neg_r <= w_a_neg;
                                r_cnt   <= c_cnt_init;
                                r_state <= S_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DIV: begin
                    if (nullify) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (!w_trial[WIDTH]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt - c_cnt_one;
                        if (r_cnt == '0) begin
                            r_state <= S_FIXUP;
                        end
                    end
                end
                S_FIXUP: begin
                    r_state <= S_IDLE;
                    if (!nullify) begin
                        r_hi   <= w_rem_fix;
                        r_lo   <= w_quo_fix;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_hilo_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_mdu
// Description : Directed self-checking bench for hilo_mdu. Expected HI/LO
//               pairs are queued when an op is issued and compared whenever
//               the DUT pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        nullify;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    hilo_mdu #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs      (rs),
        .rt      (rt),
        .nullify (nullify),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [31:0] h, input logic [31:0] l);
        m_hi = h;
        m_lo = l;
        exp_q.push_back({h, l});
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_div(input string tag, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        push_exp(eh, el);
        issue(o, a, b);
        n = 0;
        while (busy && n < 100) begin
            n++;
            cycles(1);
        end
        check({tag, "_busy_cycles"}, n, 33);
        check({tag, "_done"}, done, 1'b1);
    endtask

    // Scoreboard: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {hi, lo}, 64'hx);
            end else begin
                check("done_hilo", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; op = '0; rs = '0; rt = '0; nullify = 1'b0;
        #2;
        check("reset_hilo", {hi, lo}, 64'h0);
        check("reset_busy_done", {busy, done}, 2'b00);
        cycles(2);
        reset = 1'b1;
        cycles(3);
        check("idle_hilo", {hi, lo}, 64'h0);
        check("idle_busy_done", {busy, done}, 2'b00);

        // Multiply
        push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
        check("mult_done_t1", done, 1'b1);
        check("mult_busy", busy, 1'b0);
        push_exp(32'h0000_0002, 32'hFFFF_FFFA);
        issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        check("multu_done_t1", done, 1'b1);
        cycles(1);

        // Divide
        run_div("div_neg7_2",   3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("divu_100_7",   3'd3, 32'd100,       32'd7,        32'd2,         32'd14);
        run_div("divu_by_zero", 3'd3, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF);
        run_div("div_by_zero",  3'd2, 32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_div("div_min_m1",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000);
        cycles(1);

        // Abort a divide with nullify during cycle T+10
        issue(3'd2, 32'd100, 32'd3);
        cycles(9);
        nullify = 1'b1;
        cycles(1);
        nullify = 1'b0;
        check("abort_busy_t11", busy, 1'b0);
        check("abort_hilo", {hi, lo}, {m_hi, m_lo});
        cycles(40);
        check("abort_hilo_late", {hi, lo}, {m_hi, m_lo});

        // nullify blocks a same-cycle start
        nullify = 1'b1;
        issue(3'd4, 32'h0000_AAAA, 32'd0);
        nullify = 1'b0;
        cycles(2);
        check("nullify_start_hi", hi, m_hi);
        check("nullify_start_busy", busy, 1'b0);

        // MTHI / MTLO
        push_exp(32'h0000_1111, m_lo);
        issue(3'd4, 32'h0000_1111, 32'd0);
        check("mthi_hilo", {hi, lo}, {m_hi, m_lo});
        push_exp(m_hi, 32'h0000_2222);
        issue(3'd5, 32'h0000_2222, 32'd0);
        check("mtlo_hilo", {hi, lo}, {m_hi, m_lo});

        // Reserved op is ignored
        issue(3'd6, 32'h5555_5555, 32'd1);
        cycles(2);
        check("reserved_op", {hi, lo, busy}, {m_hi, m_lo, 1'b0});

        // start with MTLO during a divide is ignored
        push_exp(32'd0, 32'd100);
        issue(3'd3, 32'd1000, 32'd10);
        cycles(4);
        issue(3'd5, 32'h0000_DEAD, 32'd0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            cycles(1);
        end
        check("busy_start_ignored", {hi, lo}, {m_hi, m_lo});
        cycles(2);
        check("busy_start_lo_stable", lo, 32'd100);

        // Asynchronous reset in the middle of a divide (cycle T+20)
        issue(3'd2, 32'd12345, 32'd7);
        cycles(19);
        #2 reset = 1'b0;
        #1;
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_hilo", {hi, lo}, 64'h0);
        m_hi = '0;
        m_lo = '0;
        cycles(2);
        reset = 1'b1;
        cycles(40);
        check("post_reset_hilo", {hi, lo, busy, done}, {64'h0, 2'b00});

        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
